// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the multi-channel UART receive hub.
package sim_uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
      return clock_frequency / baud_rate;
   endfunction

endpackage

// File: rtl/sim_uart_rx_chan.sv
// One 8N1 receive channel: line synchroniser, framing FSM, bit counter and shift register.
module sim_uart_rx_chan
   import sim_uart_pkg::*;
#(
   parameter int ClksPerBit = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       enable_i,
   output logic       push_o,
   output logic [7:0] data_o,
   output logic       frame_err_o
);

   localparam int CntW = $clog2(ClksPerBit);
   localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);

   logic [1:0]      sync_q;
   logic            rx_s;
   rx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            err_q, err_d;

   // Reset to 1 so a reset never looks like a start bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], rx_i};
   end

   assign rx_s = sync_q[1];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every output of this block gets a default first, otherwise untouched paths infer latches.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      err_d   = 1'b0;
      push_o  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = RX_START;
               bit_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HalfLast) begin
               cnt_d   = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BitLast) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rx_s) begin
                  push_o  = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
      // Disabling aborts any frame without reporting anything.
      if (!enable_i) begin
         state_d = RX_IDLE;
         cnt_d   = '0;
         err_d   = 1'b0;
         push_o  = 1'b0;
      end
   end

   assign data_o      = shift_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/sim_uart_rx_hub.sv
// Multi-channel UART receiver: per-channel FIFOs merged round-robin into one registered output slot.
module sim_uart_rx_hub
   import sim_uart_pkg::*;
#(
   parameter int NumChannels    = 5,
   parameter int ClockFrequency = 30_000_000,
   parameter int BaudRate       = 921_600,
   parameter int FifoDepth      = 4,
   localparam int ChanW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumChannels-1:0] uart_rx_i,
   input  logic [NumChannels-1:0] enable_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [7:0]             out_data_o,
   output logic [ChanW-1:0]       out_chan_o,
   output logic [NumChannels-1:0] frame_err_o,
   output logic [NumChannels-1:0] overflow_o
);

   localparam int ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
   localparam int AddrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW       = AddrW + 1;

   if (ClksPerBit < 4) begin : g_bad_baud
      $error("sim_uart_rx_hub: ClockFrequency/BaudRate must be at least 4");
   end
   if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
      $error("sim_uart_rx_hub: FifoDepth must be a power of two >= 2");
   end
   if (NumChannels < 1 || NumChannels > 16) begin : g_bad_chans
      $error("sim_uart_rx_hub: NumChannels must be 1..16");
   end

   logic [NumChannels-1:0] push, held, freed, full, accept, drop, head_valid, pop;
   logic [7:0]             push_data [NumChannels];
   logic [7:0]             head_data [NumChannels];
   logic [7:0]             mem_q     [NumChannels][FifoDepth];
   logic [AddrW-1:0]       wr_ptr_q  [NumChannels];
   logic [AddrW-1:0]       rd_ptr_q  [NumChannels];
   logic [CntW-1:0]        count_q   [NumChannels];

   logic                   slot_valid_q;
   logic [7:0]             slot_data_q;
   logic [ChanW-1:0]       slot_chan_q;
   logic [ChanW-1:0]       rr_q, rr_d, grant_idx;
   logic                   grant_valid, handshake, load;
   logic [NumChannels-1:0] ovf_q;

   for (genvar c = 0; c < NumChannels; c++) begin : g_chan
      sim_uart_rx_chan #(.ClksPerBit(ClksPerBit)) u_rx (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .rx_i       (uart_rx_i[c]),
         .enable_i   (enable_i[c]),
         .push_o     (push[c]),
         .data_o     (push_data[c]),
         .frame_err_o(frame_err_o[c])
      );
   end

   // A byte sitting in the output slot still counts against its channel's FIFO budget
   // until it is handed off, so FifoDepth bounds the bytes held per channel.
   always_comb begin
      int idx;
      idx         = 0;
      handshake   = slot_valid_q && out_ready_i;
      load        = !slot_valid_q || out_ready_i;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int c = 0; c < NumChannels; c++) begin
         held[c]       = slot_valid_q && (int'(slot_chan_q) == c);
         freed[c]      = handshake && held[c];
         full[c]       = (int'(count_q[c]) + int'(held[c])) >= FifoDepth;
         accept[c]     = push[c] && (!full[c] || freed[c]);
         drop[c]       = push[c] && !accept[c];
         // An empty FIFO forwards the incoming byte straight to the arbiter.
         head_valid[c] = (count_q[c] != '0) || accept[c];
         head_data[c]  = (count_q[c] != '0) ? mem_q[c][rd_ptr_q[c]] : push_data[c];
      end
      for (int i = 0; i < NumChannels; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NumChannels) idx = idx - NumChannels;
         if (!grant_valid && head_valid[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = ChanW'(idx);
         end
      end
      for (int c = 0; c < NumChannels; c++) begin
         pop[c] = load && grant_valid && (int'(grant_idx) == c);
      end
      rr_d = (int'(grant_idx) == NumChannels - 1) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_valid_q <= 1'b0;
         slot_data_q  <= '0;
         slot_chan_q  <= '0;
         rr_q         <= '0;
         ovf_q        <= '0;
         for (int c = 0; c < NumChannels; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            count_q[c]  <= '0;
         end
      end else begin
         ovf_q <= drop;
         if (load) begin
            slot_valid_q <= grant_valid;
            if (grant_valid) begin
               slot_data_q <= head_data[grant_idx];
               slot_chan_q <= grant_idx;
               rr_q        <= rr_d;
            end
         end
         for (int c = 0; c < NumChannels; c++) begin
            if (accept[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
            if (pop[c])    rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
            count_q[c] <= count_q[c] + CntW'(accept[c]) - CntW'(pop[c]);
         end
      end
   end

   // NOTE: FIFO storage has no reset; the pointers and counts alone define what is valid.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NumChannels; c++) begin
         if (accept[c]) mem_q[c][wr_ptr_q[c]] <= push_data[c];
      end
   end

   assign out_valid_o = slot_valid_q;
   assign out_data_o  = slot_data_q;
   assign out_chan_o  = slot_chan_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sim_uart_rx_hub.sv
// Scoreboard bench for sim_uart_rx_hub: serial frames in, per-channel expected byte queues out.
module tb_sim_uart_rx_hub;

   localparam int N     = 5;
   localparam int Cpb   = 30_000_000 / 921_600;
   localparam int Depth = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] uart_rx;
   logic [N-1:0] enable;
   logic         out_ready;
   logic         out_valid;
   logic [7:0]   out_data;
   logic [2:0]   out_chan;
   logic [N-1:0] frame_err;
   logic [N-1:0] overflow;

   always #5 clk = ~clk;

   sim_uart_rx_hub dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .uart_rx_i  (uart_rx),
      .enable_i   (enable),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_chan_o (out_chan),
      .frame_err_o(frame_err),
      .overflow_o (overflow)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] exp_q [N][$];
   int         err_exp [N];
   int         err_seen[N];
   int         ovf_exp [N];
   int         ovf_seen[N];
   int         log_chan[$];
   int         log_cyc [$];
   bit         rand_ready = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int pending();
      int total = 0;
      for (int c = 0; c < N; c++) total += exp_q[c].size();
      return total;
   endfunction

   task automatic wait_drain(input string tag, input int budget);
      int k = 0;
      while (pending() != 0 && k < budget) begin
         wait_clks(1);
         k++;
      end
      check({"drain_", tag}, pending(), 0);
   endtask

   task automatic check_counts(input string tag);
      for (int c = 0; c < N; c++) begin
         check($sformatf("%s_frame_err_ch%0d", tag, c), err_seen[c], err_exp[c]);
         check($sformatf("%s_overflow_ch%0d", tag, c), ovf_seen[c], ovf_exp[c]);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_data"}, int'(out_data), 0);
      check({tag, "_chan"}, int'(out_chan), 0);
      check({tag, "_frame_err"}, int'(frame_err), 0);
      check({tag, "_overflow"}, int'(overflow), 0);
   endtask

   // Drives one 8N1 frame on every channel in mask at once. The expected outcome is recorded
   // at the start of the stop bit, before the receiver can act on it. A low stop bit leaves
   // the line low for the caller to release.
   task automatic send_frame(input logic [N-1:0] mask, input logic [N-1:0][7:0] data,
                             input bit stop_bit, input bit expect_it);
      for (int c = 0; c < N; c++) if (mask[c]) uart_rx[c] = 1'b0;
      wait_clks(Cpb);
      for (int b = 0; b < 8; b++) begin
         for (int c = 0; c < N; c++) if (mask[c]) uart_rx[c] = data[c][b];
         wait_clks(Cpb);
      end
      for (int c = 0; c < N; c++) begin
         if (mask[c] && expect_it) begin
            if (!stop_bit)                     err_exp[c]++;
            else if (exp_q[c].size() < Depth) exp_q[c].push_back(data[c]);
            else                               ovf_exp[c]++;
         end
         if (mask[c]) uart_rx[c] = stop_bit;
      end
      wait_clks(Cpb);
      if (stop_bit) wait_clks(Cpb);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: counts error pulses and checks every handshaken beat against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         for (int c = 0; c < N; c++) begin
            if (frame_err[c]) err_seen[c]++;
            if (overflow[c])  ovf_seen[c]++;
         end
         if (out_valid && out_ready) begin
            int ch;
            ch = int'(out_chan);
            log_chan.push_back(ch);
            log_cyc.push_back(cyc);
            if (ch >= N) begin
               check("beat_chan_range", ch, N - 1);
            end else begin
               check($sformatf("beat_expected_ch%0d", ch), int'(exp_q[ch].size() > 0), 1);
               if (exp_q[ch].size() > 0) begin
                  logic [7:0] e;
                  e = exp_q[ch].pop_front();
                  check($sformatf("beat_data_ch%0d", ch), int'(out_data), int'(e));
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0][7:0] d;
      logic [N-1:0]      mask;
      int                base;

      for (int c = 0; c < N; c++) begin
         err_exp[c] = 0; err_seen[c] = 0; ovf_exp[c] = 0; ovf_seen[c] = 0;
      end
      rst = 1'b1; uart_rx = '1; enable = '1; out_ready = 1'b1; d = '0;
      wait_clks(3);
      check_reset_outputs("reset");
      wait_clks(1);
      rst = 1'b0;
      wait_clks(5);

      // Single byte on channel 2.
      d = '0; d[2] = 8'hA5;
      send_frame(5'b00100, d, 1'b1, 1'b1);
      wait_drain("single", 400);
      check_counts("single");

      // Three channels in lockstep, fresh round-robin pointer.
      rst = 1'b1; wait_clks(2); rst = 1'b0; wait_clks(2);
      base = log_chan.size();
      d = '0; d[0] = 8'h11; d[1] = 8'h22; d[3] = 8'h33;
      send_frame(5'b01011, d, 1'b1, 1'b1);
      wait_drain("lockstep", 400);
      check("lockstep_beats", log_chan.size() - base, 3);
      if (log_chan.size() >= base + 3) begin
         check("lockstep_order0", log_chan[base], 0);
         check("lockstep_order1", log_chan[base + 1], 1);
         check("lockstep_order2", log_chan[base + 2], 3);
         check("lockstep_gap1", log_cyc[base + 1] - log_cyc[base], 1);
         check("lockstep_gap2", log_cyc[base + 2] - log_cyc[base + 1], 1);
      end

      // Six bytes into a stalled channel 0.
      out_ready = 1'b0;
      base = log_chan.size();
      for (int i = 0; i < 6; i++) begin
         d = '0; d[0] = 8'(i);
         send_frame(5'b00001, d, 1'b1, 1'b1);
      end
      wait_clks(20);
      check("stall_overflow_ch0", ovf_seen[0], 2);
      out_ready = 1'b1;
      wait_drain("stall", 400);
      check("stall_beats", log_chan.size() - base, 4);
      check_counts("stall");

      // Framing error followed by a long break on channel 4.
      base = log_chan.size();
      d = '0; d[4] = 8'h81;
      send_frame(5'b10000, d, 1'b0, 1'b1);
      wait_clks(100 * Cpb);
      uart_rx[4] = 1'b1;
      wait_clks(2 * Cpb);
      check("break_no_beat", log_chan.size() - base, 0);
      d = '0; d[4] = 8'h5A;
      send_frame(5'b10000, d, 1'b1, 1'b1);
      wait_drain("break", 400);
      check_counts("break");

      // Short glitch, then reset in the middle of a 0xFF frame.
      base = log_chan.size();
      uart_rx[1] = 1'b0; wait_clks(10); uart_rx[1] = 1'b1;
      wait_clks(3 * Cpb);
      check("glitch_no_beat", log_chan.size() - base, 0);
      check_counts("glitch");
      uart_rx[1] = 1'b0; wait_clks(Cpb);
      uart_rx[1] = 1'b1; wait_clks(3 * Cpb);
      rst = 1'b1;
      check_reset_outputs("midframe_reset");
      wait_clks(3);
      rst = 1'b0;
      wait_clks(7 * Cpb);
      d = '0; d[1] = 8'h3C;
      send_frame(5'b00010, d, 1'b1, 1'b1);
      wait_drain("after_reset", 400);
      check("after_reset_beats", log_chan.size() - base, 1);

      // Enable dropped mid-frame on channel 2.
      base = log_chan.size();
      d = '0;
      fork
         send_frame(5'b00100, d, 1'b1, 1'b0);
         begin
            wait_clks(5 * Cpb);
            enable[2] = 1'b0;
            wait_clks(6 * Cpb);
            enable[2] = 1'b1;
         end
      join
      wait_clks(2 * Cpb);
      check("disable_no_beat", log_chan.size() - base, 0);
      d = '0; d[2] = 8'h7E;
      send_frame(5'b00100, d, 1'b1, 1'b1);
      wait_drain("reenable", 400);
      check("reenable_beats", log_chan.size() - base, 1);
      check_counts("reenable");

      // Random channel mixes with random back-pressure.
      rand_ready = 1'b1;
      for (int it = 0; it < 12; it++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int c = 0; c < N; c++) d[c] = 8'($urandom);
         send_frame(mask, d, 1'b1, 1'b1);
         wait_clks($urandom_range(0, 40));
      end
      rand_ready = 1'b0;
      wait_clks(1);
      out_ready = 1'b1;
      wait_drain("random", 1000);
      check_counts("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
